gau_fil_stream: RTL and testbench
=================================

GAU_FIL_STREAM -- requirements
Module: gau_fil_stream

Interface
REQ-001 Parameter DSIZE, default 8, pixel bit width.
REQ-002 Parameter IMG_W, default 640, pixels per input row (>=3).
REQ-003 Parameter IMG_H, default 480, rows per input frame (>=3).
REQ-004 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 i_rst  input  1  reset: synchronous, active-high.
REQ-006 i_valid  input  1  input pixel qualifier; a pixel is accepted on every i_clk edge with i_valid=1.
REQ-007 i_sof  input  1  marks the accepted pixel as frame position (col 0, row 0); ignored when i_valid=0.
REQ-008 i_pixel  input  DSIZE  raster-order input pixel, unsigned.
REQ-009 o_valid  output  1  output pixel qualifier, one-cycle pulse per output pixel.
REQ-010 o_sof  output  1  high with the first output pixel of a frame.
REQ-011 o_eol  output  1  high with the last output pixel of each output row.
REQ-012 o_pixel  output  DSIZE  filtered pixel.
REQ-013 o_busy  output  1  high while the state machine is in ACTIVE.

Function
REQ-014 Block SHALL apply the 3x3 kernel [1 2 1; 2 4 2; 1 2 1]/16 to a streaming frame using two internal line buffers of IMG_W x DSIZE and a 3x3 window register.
REQ-015 Output frame SHALL contain interior positions only: (IMG_W-2) x (IMG_H-2) pixels; no border padding.
REQ-016 State machine SHALL have states IDLE and ACTIVE; IDLE->ACTIVE on accepted pixel with i_sof=1; ACTIVE->IDLE after acceptance of pixel (IMG_W-1, IMG_H-1).
REQ-017 In IDLE, accepted pixels without i_sof SHALL be discarded: no counter, buffer or output change.
REQ-018 Accepted pixel with i_sof=1 in ACTIVE SHALL restart the frame at (0,0); outputs SHALL be gated until row 2 of the new frame.
REQ-019 Column counter SHALL wrap IMG_W-1 -> 0 and increment the row counter; counters SHALL change only on accepted pixels.
REQ-020 Acceptance of pixel (x,y) with x>=2 and y>=2 SHALL produce exactly one output pixel for centre (x-1,y-1), with o_valid high on the following cycle (latency 1 cycle).
REQ-021 i_valid=0 cycles SHALL stall the block: no state change, o_valid=0.
REQ-022 Weighted sum SHALL be computed exactly at DSIZE+4 bits with no intermediate truncation; o_pixel = sum >> 4 (see REQ-027).
REQ-023 o_sof SHALL accompany centre (1,1); o_eol SHALL accompany centre (IMG_W-2, y).
REQ-024 o_pixel SHALL hold its last value while o_valid=0.

Reset
REQ-025 With i_rst=1 at a rising edge: o_valid, o_sof, o_eol, o_busy, o_pixel SHALL be 0, counters 0, state IDLE; line-buffer contents are not reset.
REQ-026 Reset asserted mid-frame SHALL abort the frame; no output SHALL appear until a new i_sof pixel and two full rows are accepted.

Configuration
REQ-027 Macro GAU_ROUND_EN: when defined, o_pixel = (sum + 8) >> 4 (round half up, max 255 for DSIZE=8, no overflow); when undefined, o_pixel = sum >> 4 (truncate).

Verification
REQ-028 IMG_W=8, IMG_H=6, uniform frame value 100, continuous i_valid -> exactly 24 o_valid pulses, all o_pixel=100, one o_sof, 4 o_eol.
REQ-029 IMG_W=8, IMG_H=6, zeros except 255 at (3,3), GAU_ROUND_EN defined -> centre (3,3)=64, orthogonal neighbours=32, diagonal neighbours=16, all others 0.
REQ-030 Same frame with single value 2 at (3,3) -> centre (3,3)=1 with GAU_ROUND_EN, 0 without.
REQ-031 Uniform 100 frame with i_valid toggling every other cycle -> identical 24 outputs, each o_valid one cycle after the triggering accepted pixel.
REQ-032 i_rst pulsed after 20 accepted pixels, then 10 pixels without i_sof, then full frame with i_sof -> no output before new frame; new frame yields 24 correct outputs, o_busy 0 during discarded pixels.
REQ-033 i_sof reasserted at pixel 30 of a frame -> outputs only from new frame row 2 onward, 24 outputs total for the new frame.

Source files
------------

// File: rtl/gau_fil_stream_if.sv
// Pixel stream bundle for gau_fil_stream: raster input side and filtered output side.
// Valid-only handshake: a beat transfers on every clock edge with *_valid=1; there is no ready/backpressure.
interface gau_fil_stream_if #(
  parameter int DSIZE = 8
);
  logic             i_valid;
  logic             i_sof;
  logic [DSIZE-1:0] i_pixel;
  logic             o_valid;
  logic             o_sof;
  logic             o_eol;
  logic [DSIZE-1:0] o_pixel;
  logic             o_busy;

  modport master (
    output i_valid, i_sof, i_pixel,
    input  o_valid, o_sof, o_eol, o_pixel, o_busy
  );

  modport slave (
    input  i_valid, i_sof, i_pixel,
    output o_valid, o_sof, o_eol, o_pixel, o_busy
  );
endinterface

// File: rtl/gau_fil_stream.sv
// Streaming 3x3 Gaussian filter ([1 2 1; 2 4 2; 1 2 1]/16), interior positions only, 1-cycle latency.
// Optional macro GAU_ROUND_EN: round half up instead of truncating the weighted sum.
module gau_fil_stream #(
  parameter int DSIZE = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic               i_clk,
  input  logic               i_rst,
  gau_fil_stream_if.slave    bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int SW = DSIZE + 4;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [DSIZE-1:0] win_q [3][3];
  logic [DSIZE-1:0] win_d [3][3];
  logic             o_valid_q, o_valid_d;
  logic             o_sof_q, o_sof_d;
  logic             o_eol_q, o_eol_d;
  logic [DSIZE-1:0] o_pixel_q, o_pixel_d;

  // lb0 holds row y-1, lb1 holds row y-2, both indexed by column
  logic [DSIZE-1:0] lb0_mem [IMG_W];
  logic [DSIZE-1:0] lb1_mem [IMG_W];

  logic             start;
  logic             proc;
  logic [CW-1:0]    px;
  logic [RW-1:0]    py;
  logic [SW-1:0]    sum;
  logic [SW-1:0]    sum_r;

  always_comb begin
    start     = bus.i_valid & bus.i_sof;
    proc      = bus.i_valid & (start | (state_q == ACTIVE));
    px        = start ? '0 : col_q;
    py        = start ? '0 : row_q;
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    win_d     = win_q;
    o_valid_d = 1'b0;
    o_sof_d   = 1'b0;
    o_eol_d   = 1'b0;
    o_pixel_d = o_pixel_q;
    sum       = '0;
    sum_r     = '0;
    if (proc) begin
      state_d = ACTIVE;
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_mem[px];
      win_d[1][2] = lb0_mem[px];
      win_d[2][2] = bus.i_pixel;
      if (px == LAST_COL) begin
        col_d = '0;
        if (py == LAST_ROW) begin
          row_d   = '0;
          state_d = IDLE;
        end else begin
          row_d = py + RW'(1);
        end
      end else begin
        col_d = px + CW'(1);
        row_d = py;
      end
      // Full-precision sum: 16 * max pixel fits exactly in DSIZE+4 bits
      sum = SW'(win_d[0][0])        + (SW'(win_d[0][1]) << 1) + SW'(win_d[0][2])
          + (SW'(win_d[1][0]) << 1) + (SW'(win_d[1][1]) << 2) + (SW'(win_d[1][2]) << 1)
          + SW'(win_d[2][0])        + (SW'(win_d[2][1]) << 1) + SW'(win_d[2][2]);
`ifdef GAU_ROUND_EN
      sum_r = sum + SW'(8);
`else
      sum_r = sum;
`endif
      if ((px >= CW'(2)) && (py >= RW'(2))) begin
        o_valid_d = 1'b1;
        o_sof_d   = (px == CW'(2)) && (py == RW'(2));
        o_eol_d   = (px == LAST_COL);
        o_pixel_d = sum_r[SW-1:4];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      win_q     <= '{default: '0};
      o_valid_q <= 1'b0;
      o_sof_q   <= 1'b0;
      o_eol_q   <= 1'b0;
      o_pixel_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      win_q     <= win_d;
      o_valid_q <= o_valid_d;
      o_sof_q   <= o_sof_d;
      o_eol_q   <= o_eol_d;
      o_pixel_q <= o_pixel_d;
    end
  end

  // Line buffers carry no reset; stale rows are overwritten before any output uses them
  always_ff @(posedge i_clk) begin
    if (!i_rst && proc) begin
      lb0_mem[px] <= bus.i_pixel;
      lb1_mem[px] <= lb0_mem[px];
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_sof   = o_sof_q;
  assign bus.o_eol   = o_eol_q;
  assign bus.o_pixel = o_pixel_q;
  assign bus.o_busy  = (state_q == ACTIVE);

endmodule

// File: tb/tb_gau_fil_stream.sv
// Directed bench for gau_fil_stream on an 8x6 frame; expectations follow GAU_ROUND_EN when defined.
module tb_gau_fil_stream;

  localparam int DSIZE = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int N_OUT = (IMG_W - 2) * (IMG_H - 2);

`ifdef GAU_ROUND_EN
  localparam logic [7:0] IMP_C = 8'd64;
  localparam logic [7:0] IMP_O = 8'd32;
  localparam logic [7:0] IMP_D = 8'd16;
  localparam logic [7:0] SMALL_C = 8'd1;
`else
  localparam logic [7:0] IMP_C = 8'd63;
  localparam logic [7:0] IMP_O = 8'd31;
  localparam logic [7:0] IMP_D = 8'd15;
  localparam logic [7:0] SMALL_C = 8'd0;
`endif

  logic i_clk;
  logic i_rst;
  int   checks;
  int   errors;

  logic [7:0] img [IMG_H][IMG_W];
  logic [DSIZE-1:0] exp_q [$];
  logic [DSIZE-1:0] got_q [$];
  bit               got_sof_q [$];
  bit               got_eol_q [$];

  gau_fil_stream_if #(.DSIZE(DSIZE)) bus ();

  gau_fil_stream #(
    .DSIZE (DSIZE),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (bus.o_valid === 1'b1) begin
      got_q.push_back(bus.o_pixel);
      got_sof_q.push_back(bus.o_sof);
      got_eol_q.push_back(bus.o_eol);
    end
  end

  // driver tasks (all end #1 after a rising edge)
  task automatic reset_dut();
    i_rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_sof = 1'b0;
    bus.i_pixel = '0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] p, input logic sof);
    bus.i_valid = 1'b1;
    bus.i_sof = sof;
    bus.i_pixel = p;
    @(posedge i_clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send_frame();
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        send_pixel(img[y][x], (x == 0) && (y == 0));
  endtask

  task automatic fill(input logic [7:0] v);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        img[y][x] = v;
  endtask

  task automatic clear_capture();
    got_q.delete();
    got_sof_q.delete();
    got_eol_q.delete();
    exp_q.delete();
  endtask

  // scoreboard: compare captured outputs against exp_q plus sof/eol placement
  task automatic score(input string name);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s pixel[%0d]: got %0d expected %0d", name, i, got_q[i], exp_q[i]);
      end
      checks++;
      if (got_sof_q[i] !== (i == 0)) begin
        errors++;
        $display("FAIL %s sof[%0d]: got %0b expected %0b", name, i, got_sof_q[i], (i == 0));
      end
      checks++;
      if (got_eol_q[i] !== ((i % (IMG_W - 2)) == (IMG_W - 3))) begin
        errors++;
        $display("FAIL %s eol[%0d]: got %0b expected %0b", name, i, got_eol_q[i],
                 ((i % (IMG_W - 2)) == (IMG_W - 3)));
      end
    end
  endtask

  task automatic test_reset();
    reset_dut();
    checks += 5;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset o_valid: got %b expected 0", bus.o_valid); end
    if (bus.o_sof !== 1'b0) begin errors++; $display("FAIL reset o_sof: got %b expected 0", bus.o_sof); end
    if (bus.o_eol !== 1'b0) begin errors++; $display("FAIL reset o_eol: got %b expected 0", bus.o_eol); end
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset o_busy: got %b expected 0", bus.o_busy); end
    if (bus.o_pixel !== '0) begin errors++; $display("FAIL reset o_pixel: got %0d expected 0", bus.o_pixel); end
  endtask

  task automatic test_uniform();
    fill(8'd100);
    clear_capture();
    send_frame();
    idle(2);
    for (int i = 0; i < N_OUT; i++) exp_q.push_back(8'd100);
    score("uniform");
    checks++;
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL uniform busy_after: got %b expected 0", bus.o_busy); end
  endtask

  task automatic test_impulse(input logic [7:0] v, input string name);
    int dx, dy;
    fill(8'd0);
    img[3][3] = v;
    clear_capture();
    send_frame();
    idle(2);
    for (int cy = 1; cy <= IMG_H - 2; cy++)
      for (int cx = 1; cx <= IMG_W - 2; cx++) begin
        dx = (cx > 3) ? cx - 3 : 3 - cx;
        dy = (cy > 3) ? cy - 3 : 3 - cy;
        if (v == 8'd255)
          exp_q.push_back((dx == 0 && dy == 0) ? IMP_C :
                          (dx + dy == 1)       ? IMP_O :
                          (dx == 1 && dy == 1) ? IMP_D : 8'd0);
        else
          exp_q.push_back((dx == 0 && dy == 0) ? SMALL_C : 8'd0);
      end
    score(name);
  endtask

  task automatic test_toggle();
    logic exp_v;
    fill(8'd100);
    clear_capture();
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) begin
        send_pixel(img[y][x], (x == 0) && (y == 0));
        exp_v = (x >= 2) && (y >= 2);
        checks++;
        if (bus.o_valid !== exp_v) begin
          errors++;
          $display("FAIL toggle latency (%0d,%0d): got %b expected %b", x, y, bus.o_valid, exp_v);
        end
        idle(1);
        checks++;
        if (bus.o_valid !== 1'b0) begin
          errors++;
          $display("FAIL toggle stall (%0d,%0d): got %b expected 0", x, y, bus.o_valid);
        end
      end
    idle(2);
    for (int i = 0; i < N_OUT; i++) exp_q.push_back(8'd100);
    score("toggle");
  endtask

  task automatic test_reset_mid();
    fill(8'd100);
    for (int i = 0; i < 20; i++) send_pixel(8'd77, i == 0);
    checks++;
    if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL reset_mid busy_before: got %b expected 1", bus.o_busy); end
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    clear_capture();
    for (int i = 0; i < 10; i++) begin
      send_pixel(8'd200, 1'b0);
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid discard[%0d]: got busy=%b valid=%b expected 0 0", i, bus.o_busy, bus.o_valid);
      end
    end
    checks++;
    if (got_q.size() !== 0) begin errors++; $display("FAIL reset_mid early_out: got %0d expected 0", got_q.size()); end
    send_frame();
    idle(2);
    for (int i = 0; i < N_OUT; i++) exp_q.push_back(8'd100);
    score("reset_mid");
  endtask

  task automatic test_sof_restart();
    for (int i = 0; i < 30; i++) send_pixel(8'd50, i == 0);
    idle(1);
    clear_capture();
    fill(8'd100);
    send_frame();
    idle(2);
    for (int i = 0; i < N_OUT; i++) exp_q.push_back(8'd100);
    score("sof_restart");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_uniform();
    test_impulse(8'd255, "impulse255");
    test_impulse(8'd2, "impulse2");
    test_toggle();
    test_reset_mid();
    test_sof_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
